xbar_ctrl: RTL and testbench

Sequencing controller for the distribution crossbar (`xbar`).
- Holds a table of up to `DEPTH` per-step mux-select vectors, loaded by a config port.
- On `i_start`, walks the table for a programmed number of steps and iterations, one step per accepted input beat. For each step it drives the crossbar select bus and pops the upstream input buffer.
- Produces `o_dist_valid` aligned with the crossbar's registered output, with backpressure from the multiplier array.

---
 rtl/sigma_dist_pkg.sv | 14 +
 rtl/xbar_sel_table.sv | 29 ++
 rtl/xbar_ctrl.sv | 110 +++++++++++
 tb/tb_xbar_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sigma_dist_pkg.sv
// Shared definitions for the distribution crossbar sequencing logic.
package sigma_dist_pkg;

   localparam int NUM_PES_DEF  = 64;
   localparam int LOG2_PES_DEF = 6;
   localparam int SEL_W_DEF    = NUM_PES_DEF * LOG2_PES_DEF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/xbar_sel_table.sv
// Per-step mux-select register file: one synchronous write port, one combinational read port.
module xbar_sel_table #(
   parameter int DEPTH      = 16,
   parameter int LOG2_DEPTH = 4,
   parameter int SEL_W      = sigma_dist_pkg::SEL_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [LOG2_DEPTH-1:0] wr_addr,
   input  logic [SEL_W-1:0]      wr_data,
   input  logic [LOG2_DEPTH-1:0] rd_addr,
   output logic [SEL_W-1:0]      rd_data
);

   logic [SEL_W-1:0] mem [DEPTH];

   // Cleared on reset so every PE falls back to selecting input 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/xbar_ctrl.sv
// Sequencing controller: walks the select table per accepted beat and tracks the xbar output valid.
module xbar_ctrl
   import sigma_dist_pkg::*;
#(
   parameter int NUM_PES    = NUM_PES_DEF,
   parameter int LOG2_PES   = LOG2_PES_DEF,
   parameter int DEPTH      = 16,
   parameter int LOG2_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_cfg_wr_en,
   input  logic [LOG2_DEPTH-1:0]        i_cfg_wr_addr,
   input  logic [LOG2_PES*NUM_PES-1:0]  i_cfg_wr_data,
   input  logic                         i_start,
   input  logic [LOG2_DEPTH:0]          i_num_steps,
   input  logic [7:0]                   i_num_iters,
   input  logic                         i_data_valid,
   output logic                         o_data_ready,
   input  logic                         i_pe_ready,
   output logic [LOG2_PES*NUM_PES-1:0]  o_mux_bus,
   output logic                         o_dist_valid,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_cfg_err
);

   localparam int SEL_W = LOG2_PES * NUM_PES;
   localparam int CNT_W = LOG2_DEPTH + 1;

   state_t                state, state_n;
   logic [CNT_W-1:0]      steps, steps_clamp;
   logic [7:0]            iters, iters_clamp;
   logic [LOG2_DEPTH-1:0] step_ptr;
   logic [7:0]            iter_cnt;
   logic                  issue, last_step, last_iter, start_ok, tbl_we;
   logic                  vld_p1, cfg_err_p1;
   logic [SEL_W-1:0]      rd_data;

   assign tbl_we = i_cfg_wr_en && (state == ST_IDLE);

   xbar_sel_table #(
      .DEPTH      (DEPTH),
      .LOG2_DEPTH (LOG2_DEPTH),
      .SEL_W      (SEL_W)
   ) u_table (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (tbl_we),
      .wr_addr (i_cfg_wr_addr),
      .wr_data (i_cfg_wr_data),
      .rd_addr (step_ptr),
      .rd_data (rd_data)
   );

   assign steps_clamp = (i_num_steps > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : i_num_steps;
   assign iters_clamp = (i_num_iters == 8'd0) ? 8'd1 : i_num_iters;
   assign start_ok    = (state == ST_IDLE) && i_start;
   assign issue       = (state == ST_RUN) && i_data_valid && i_pe_ready;
   assign last_step   = ({1'b0, step_ptr} == (steps - CNT_W'(1)));
   assign last_iter   = (iter_cnt == (iters - 8'd1));

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  if (i_start) state_n = (steps_clamp == '0) ? ST_DRAIN : ST_RUN;
         ST_RUN:   if (issue && last_step && last_iter) state_n = ST_DRAIN;
         ST_DRAIN: state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         steps      <= '0;
         iters      <= '0;
         step_ptr   <= '0;
         iter_cnt   <= '0;
         vld_p1     <= 1'b0;
         cfg_err_p1 <= 1'b0;
      end else begin
         state      <= state_n;
         // p1: issued beat appears on the registered xbar output one cycle later.
         vld_p1     <= issue;
         cfg_err_p1 <= i_cfg_wr_en && (state != ST_IDLE);
         if (start_ok) begin
            steps    <= steps_clamp;
            iters    <= iters_clamp;
            step_ptr <= '0;
            iter_cnt <= '0;
         end else if (issue) begin
            if (last_step) begin
               step_ptr <= '0;
               iter_cnt <= iter_cnt + 8'd1;
            end else begin
               step_ptr <= step_ptr + LOG2_DEPTH'(1);
            end
         end
      end
   end

   assign o_data_ready = issue;
   assign o_mux_bus    = (state == ST_RUN) ? rd_data : '0;
   assign o_dist_valid = vld_p1;
   assign o_busy       = (state != ST_IDLE);
   assign o_done       = (state == ST_DRAIN);
   assign o_cfg_err    = cfg_err_p1;

endmodule

// File: tb/tb_xbar_ctrl.sv
// Randomized bench for xbar_ctrl against a beat-counting reference model.
module tb_xbar_ctrl;

   localparam int NUM_PES = 64;
   localparam int LOG2_PES = 6;
   localparam int DEPTH = 16;
   localparam int LOG2_DEPTH = 4;
   localparam int SEL_W = NUM_PES * LOG2_PES;

   logic clk = 1'b0;
   logic rst;
   logic i_cfg_wr_en;
   logic [LOG2_DEPTH-1:0] i_cfg_wr_addr;
   logic [SEL_W-1:0] i_cfg_wr_data;
   logic i_start;
   logic [LOG2_DEPTH:0] i_num_steps;
   logic [7:0] i_num_iters;
   logic i_data_valid;
   logic o_data_ready;
   logic i_pe_ready;
   logic [SEL_W-1:0] o_mux_bus;
   logic o_dist_valid, o_busy, o_done, o_cfg_err;

   int checks = 0;
   int errors = 0;
   logic [SEL_W-1:0] model_tbl [DEPTH];

   always #5 clk = ~clk;

   xbar_ctrl #(
      .NUM_PES(NUM_PES), .LOG2_PES(LOG2_PES), .DEPTH(DEPTH), .LOG2_DEPTH(LOG2_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .i_cfg_wr_en(i_cfg_wr_en), .i_cfg_wr_addr(i_cfg_wr_addr), .i_cfg_wr_data(i_cfg_wr_data),
      .i_start(i_start), .i_num_steps(i_num_steps), .i_num_iters(i_num_iters),
      .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_pe_ready(i_pe_ready),
      .o_mux_bus(o_mux_bus), .o_dist_valid(o_dist_valid), .o_busy(o_busy),
      .o_done(o_done), .o_cfg_err(o_cfg_err)
   );

   function automatic logic [SEL_W-1:0] rand_vec();
      logic [SEL_W-1:0] v;
      for (int k = 0; k < SEL_W / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic idle_inputs();
      i_cfg_wr_en = 0; i_cfg_wr_addr = '0; i_cfg_wr_data = '0;
      i_start = 0; i_num_steps = '0; i_num_iters = '0;
      i_data_valid = 0; i_pe_ready = 0;
   endtask

   task automatic cfg_write(input int addr, input logic [SEL_W-1:0] data);
      @(negedge clk);
      i_cfg_wr_en = 1; i_cfg_wr_addr = addr[LOG2_DEPTH-1:0]; i_cfg_wr_data = data;
      model_tbl[addr] = data;
      @(negedge clk);
      i_cfg_wr_en = 0;
      #1;
      checks++; if (o_cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_idle_err got=%b exp=0", o_cfg_err); end
   endtask

   // One job: model expects beat n to present table[n % steps]; done follows the final beat.
   task automatic run_job(input int n_steps, input int n_iters, input int vprob, input int rprob,
                          input int stall_at, input int busy_wr_at, input bit wr_with_start, input bit b2b);
      int st, it, total, issued, cyc, pulses;
      bit prev_issue, prev_err, v, r, wr, exp_rdy;
      logic [SEL_W-1:0] wd;
      st = (n_steps > DEPTH) ? DEPTH : n_steps;
      it = (n_iters == 0) ? 1 : n_iters;
      total = st * it;
      @(negedge clk);
      i_start = 1; i_num_steps = n_steps[LOG2_DEPTH:0]; i_num_iters = n_iters[7:0];
      i_data_valid = 1'($urandom); i_pe_ready = 1'($urandom);
      if (wr_with_start) begin
         wd = rand_vec();
         i_cfg_wr_en = 1; i_cfg_wr_addr = '0; i_cfg_wr_data = wd;
         model_tbl[0] = wd;
      end
      #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL start_busy got=%b exp=0", o_busy); end
      checks++; if (o_data_ready !== 1'b0) begin errors++; $display("FAIL start_ready got=%b exp=0", o_data_ready); end
      checks++; if (o_mux_bus !== '0) begin errors++; $display("FAIL start_mux got=%h exp=0", o_mux_bus); end
      prev_issue = 0; prev_err = 0; issued = 0; cyc = 0; pulses = 0;
      while (1) begin
         @(negedge clk);
         i_start = 0; i_cfg_wr_en = 0;
         v = ($urandom_range(99) < vprob);
         r = ($urandom_range(99) < rprob);
         if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 2) r = 0;
         wr = (cyc == busy_wr_at);
         if (wr) begin i_cfg_wr_en = 1; i_cfg_wr_addr = '0; i_cfg_wr_data = rand_vec(); end
         i_data_valid = v; i_pe_ready = r;
         #1;
         if (o_dist_valid) pulses++;
         checks++; if (o_dist_valid !== prev_issue) begin errors++; $display("FAIL dist_valid cyc=%0d got=%b exp=%b", cyc, o_dist_valid, prev_issue); end
         checks++; if (o_cfg_err !== prev_err) begin errors++; $display("FAIL cfg_err cyc=%0d got=%b exp=%b", cyc, o_cfg_err, prev_err); end
         checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=1", cyc, o_busy); end
         prev_err = wr;
         if (issued < total) begin
            exp_rdy = v & r;
            checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL early_done cyc=%0d got=%b exp=0", cyc, o_done); end
            checks++; if (o_data_ready !== exp_rdy) begin errors++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, o_data_ready, exp_rdy); end
            checks++; if (o_mux_bus !== model_tbl[issued % st]) begin errors++; $display("FAIL mux beat=%0d got=%h exp=%h", issued, o_mux_bus, model_tbl[issued % st]); end
            prev_issue = exp_rdy;
            if (exp_rdy) issued++;
         end else begin
            checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL done got=%b exp=1", o_done); end
            checks++; if (o_data_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got=%b exp=0", o_data_ready); end
            checks++; if (o_mux_bus !== '0) begin errors++; $display("FAIL drain_mux got=%h exp=0", o_mux_bus); end
            break;
         end
         cyc++;
         if (cyc > 6000) begin errors++; $display("FAIL job_timeout issued=%0d exp=%0d", issued, total); break; end
      end
      checks++; if (pulses !== total) begin errors++; $display("FAIL valid_count got=%0d exp=%0d", pulses, total); end
      if (!b2b) begin
         @(negedge clk);
         idle_inputs();
         #1;
         checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_busy got=%b exp=0", o_busy); end
         checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL post_done got=%b exp=0", o_done); end
         checks++; if (o_dist_valid !== 1'b0) begin errors++; $display("FAIL post_valid got=%b exp=0", o_dist_valid); end
         checks++; if (o_cfg_err !== prev_err) begin errors++; $display("FAIL post_cfg_err got=%b exp=%b", o_cfg_err, prev_err); end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      for (int k = 0; k < DEPTH; k++) model_tbl[k] = '0;
      #1;
      checks++; if ({o_busy, o_done, o_dist_valid, o_cfg_err, o_data_ready} !== 5'b0) begin errors++; $display("FAIL reset_outs got=%b exp=00000", {o_busy, o_done, o_dist_valid, o_cfg_err, o_data_ready}); end
      checks++; if (o_mux_bus !== '0) begin errors++; $display("FAIL reset_mux got=%h exp=0", o_mux_bus); end
   endtask

   task automatic test_load_single();
      logic [SEL_W-1:0] e0, e1;
      for (int p = 0; p < NUM_PES; p++) begin
         e0[p*LOG2_PES +: LOG2_PES] = 6'd3;
         e1[p*LOG2_PES +: LOG2_PES] = p[5:0];
      end
      cfg_write(0, e0);
      cfg_write(1, e1);
      run_job(2, 1, 100, 100, -1, -1, 0, 0);
   endtask

   task automatic test_multi_iter_stall();
      cfg_write(2, rand_vec());
      run_job(3, 2, 100, 100, 2, -1, 0, 0);
   endtask

   task automatic test_bubbles();
      for (int k = 0; k < DEPTH; k++) cfg_write(k, rand_vec());
      run_job(4, 1, 50, 100, -1, -1, 0, 0);
      run_job(7, 3, 60, 70, -1, -1, 0, 0);
   endtask

   task automatic test_boundaries();
      run_job(0, 3, 100, 100, -1, -1, 0, 0);
      run_job(20, 1, 100, 100, -1, -1, 0, 0);
      run_job(5, 0, 100, 100, -1, -1, 0, 0);
      run_job(1, 255, 90, 90, -1, -1, 0, 0);
   endtask

   task automatic test_cfg_busy();
      run_job(4, 2, 100, 100, -1, 1, 0, 0);
      run_job(2, 1, 100, 100, -1, -1, 0, 0);
   endtask

   task automatic test_same_cycle_write();
      run_job(3, 1, 100, 100, -1, -1, 1, 0);
   endtask

   task automatic test_back_to_back();
      for (int j = 0; j < 6; j++)
         run_job($urandom_range(0, 18), $urandom_range(0, 3), 80, 80, -1, -1, 0, (j != 5));
   endtask

   task automatic test_reset_mid_job();
      for (int k = 0; k < DEPTH; k++) cfg_write(k, rand_vec());
      @(negedge clk);
      i_start = 1; i_num_steps = 5'd8; i_num_iters = 8'd1; i_data_valid = 1; i_pe_ready = 1;
      @(negedge clk);
      i_start = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      idle_inputs();
      for (int k = 0; k < DEPTH; k++) model_tbl[k] = '0;
      #1;
      checks++; if ({o_busy, o_done, o_dist_valid, o_cfg_err, o_data_ready} !== 5'b0) begin errors++; $display("FAIL midrst_outs got=%b exp=00000", {o_busy, o_done, o_dist_valid, o_cfg_err, o_data_ready}); end
      checks++; if (o_mux_bus !== '0) begin errors++; $display("FAIL midrst_mux got=%h exp=0", o_mux_bus); end
      run_job(8, 1, 100, 100, -1, -1, 0, 0);
      cfg_write(3, rand_vec());
      run_job(8, 1, 100, 100, -1, -1, 0, 0);
   endtask

   initial begin
      test_reset();
      test_load_single();
      test_multi_iter_stall();
      test_bubbles();
      test_boundaries();
      test_cfg_busy();
      test_same_cycle_write();
      test_back_to_back();
      test_reset_mid_job();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
